// File: rtl/mor1kx_monitor_pkg.sv
// mor1kx_monitor_pkg: shared decode constants, per-core state and sizing helper for the exit monitor.
package mor1kx_monitor_pkg;
    localparam logic [7:0]  OPC_NOP    = 8'h15;
    localparam logic [15:0] NOP_EXIT   = 16'h0001;
    localparam logic [15:0] NOP_REPORT = 16'h0002;
    localparam logic [4:0]  REG_R3     = 5'd3;

    typedef enum logic {RUN, DONE} core_state_e;

    function automatic int clog2_min1(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mor1kx_core_exit_tracker.sv
// mor1kx_core_exit_tracker: one core's r3 shadow, run/done state, retire counter, exit code and pending report.
module mor1kx_core_exit_tracker import mor1kx_monitor_pkg::*; #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid,
    input  logic [31:0]          insn,
    input  logic [4:0]           wbreg,
    input  logic                 wben,
    input  logic [31:0]          wbdata,
    input  logic                 clr,
    output logic                 done,
    output logic                 fail,
    output logic [31:0]          exit_code,
    output logic [CNT_WIDTH-1:0] insn_count,
    output logic                 pend,
    output logic [31:0]          pend_data
);
    core_state_e state;
    logic [31:0] r3;
    logic        run, is_nop, unused_insn;

    assign run         = valid && state == RUN;
    assign is_nop      = insn[31:24] == OPC_NOP;
    assign unused_insn = ^insn[23:16];
    assign done        = state == DONE;
    assign fail        = done && |exit_code;

    // A nop never writes a GPR, so EXIT/REPORT always see the previously committed r3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            r3         <= '0;
            exit_code  <= '0;
            insn_count <= '0;
            pend       <= 1'b0;
            pend_data  <= '0;
        end else begin
            if (run) begin
                if (wben && wbreg == REG_R3) r3 <= wbdata;
                if (!(&insn_count)) insn_count <= insn_count + CNT_WIDTH'(1);
                if (is_nop && insn[15:0] == NOP_EXIT) begin
                    state     <= DONE;
                    exit_code <= r3;
                end
            end
            if (run && is_nop && insn[15:0] == NOP_REPORT) begin
                pend      <= 1'b1;
                pend_data <= r3;
            end else if (clr) begin
                pend <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/mor1kx_multicore_exit_monitor.sv
// mor1kx_multicore_exit_monitor: N-core exit/report monitor with round-robin report stream.
// Optional idle timeout enabled by defining MOR1KX_MONITOR_TIMEOUT_EN.
module mor1kx_multicore_exit_monitor import mor1kx_monitor_pkg::*; #(
    parameter int NUMCORES       = 2,
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                               wb_clk_i,
    input  logic                               wb_rst_n_i,
    input  logic [NUMCORES-1:0]                traceport_exec_valid_i,
    input  logic [32*NUMCORES-1:0]             traceport_exec_insn_i,
    input  logic [5*NUMCORES-1:0]              traceport_exec_wbreg_i,
    input  logic [NUMCORES-1:0]                traceport_exec_wben_i,
    input  logic [32*NUMCORES-1:0]             traceport_exec_wbdata_i,
    output logic [NUMCORES-1:0]                finish_o,
    output logic                               all_finished_o,
    output logic                               fail_o,
    output logic [32*NUMCORES-1:0]             exit_code_o,
    output logic [CNT_WIDTH*NUMCORES-1:0]      insn_count_o,
    output logic                               report_valid_o,
    input  logic                               report_ready_i,
    output logic [clog2_min1(NUMCORES)-1:0]    report_core_o,
    output logic [31:0]                        report_data_o,
    output logic                               timeout_o
);
    localparam int CW  = clog2_min1(NUMCORES);
    localparam int CW1 = CW + 1;

    logic [NUMCORES-1:0]   fail_core, pend, clr;
    logic [31:0]           pdata [NUMCORES];
    logic [CW-1:0]         ptr, gnt;
    logic [2*NUMCORES-1:0] dbl;
    logic [CW:0]           off, sum;
    logic                  accept;

    for (genvar k = 0; k < NUMCORES; k++) begin : g_core
        assign clr[k] = accept && gnt == CW'(k);
        mor1kx_core_exit_tracker #(.CNT_WIDTH(CNT_WIDTH)) u_trk (
            .clk        (wb_clk_i),
            .rst_n      (wb_rst_n_i),
            .valid      (traceport_exec_valid_i[k]),
            .insn       (traceport_exec_insn_i[32*k +: 32]),
            .wbreg      (traceport_exec_wbreg_i[5*k +: 5]),
            .wben       (traceport_exec_wben_i[k]),
            .wbdata     (traceport_exec_wbdata_i[32*k +: 32]),
            .clr        (clr[k]),
            .done       (finish_o[k]),
            .fail       (fail_core[k]),
            .exit_code  (exit_code_o[32*k +: 32]),
            .insn_count (insn_count_o[CNT_WIDTH*k +: CNT_WIDTH]),
            .pend       (pend[k]),
            .pend_data  (pdata[k])
        );
    end

    // Rotate the pending vector so the first set bit is the distance from the pointer.
    always_comb begin
        dbl = {pend, pend} >> ptr;
        off = '0;
        for (int i = NUMCORES - 1; i >= 0; i--)
            if (dbl[i]) off = CW1'(i);
        sum = {1'b0, ptr} + off;
        gnt = sum >= CW1'(NUMCORES) ? CW'(sum - CW1'(NUMCORES)) : CW'(sum);
    end

    assign report_valid_o = |pend;
    assign report_core_o  = gnt;
    assign report_data_o  = pdata[gnt];
    assign accept         = report_valid_o & report_ready_i;
    assign all_finished_o = &finish_o | timeout_o;
    assign fail_o         = |fail_core | timeout_o;

    // An unaccepted grant parks the pointer on itself so core/data hold while stalled.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) ptr <= '0;
        else if (accept) ptr <= gnt == CW'(NUMCORES - 1) ? '0 : gnt + CW'(1);
        else if (report_valid_o) ptr <= gnt;
    end

`ifdef MOR1KX_MONITOR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle;
    logic          active, any_run;

    assign any_run = ~&finish_o;
    assign active  = |(traceport_exec_valid_i & ~finish_o);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            idle      <= '0;
            timeout_o <= 1'b0;
        end else if (active) begin
            idle <= '0;
        end else if (any_run && !timeout_o) begin
            idle <= idle + TW'(1);
            if (idle == TW'(TIMEOUT_CYCLES - 1)) timeout_o <= 1'b1;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign timeout_o = 1'b0;
`endif
endmodule
